// File: rtl/eth_cks_pkg.sv
// Shared types and constants for the ETH TX checksum-engine scheduler.
// Also carries the header words used elsewhere in ETH_TX.
package eth_cks_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_TRIG = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4,
        ST_GAP  = 3'd5
    } cks_state_e;

    localparam logic SRC_UDP  = 1'b0;
    localparam logic SRC_ICMP = 1'b1;

    localparam logic [15:0] IP_WORD   = 16'h4500;
    localparam logic [15:0] UDP_WORD  = 16'h0011;
    localparam logic [15:0] ICMP_WORD = 16'h0001;

    // Round-robin pick: on a tie the source that did not win last time goes.
    function automatic logic rr_pick(input logic req_udp, input logic req_icmp,
                                     input logic last_grant);
        if (req_udp && req_icmp) begin
            return ~last_grant;
        end else if (req_icmp) begin
            return SRC_ICMP;
        end
        return SRC_UDP;
    endfunction

endpackage

// File: rtl/cks_rr_arb2.sv
// Two-input round-robin arbiter. The grant is combinational; the history
// register only moves when the scheduler commits a job with the load strobe.
module cks_rr_arb2
    import eth_cks_pkg::*;
(
    input  logic clk,
    input  logic srst,
    input  logic req_udp,
    input  logic req_icmp,
    input  logic load,
    input  logic load_src,
    output logic grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (load) begin
            last_grant_d = load_src;
        end
    end

    // Reset to ICMP so that UDP wins the first tie.
    always_ff @(posedge clk) begin
        if (srst) begin
            last_grant_q <= SRC_ICMP;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign grant = rr_pick(req_udp, req_icmp, last_grant_q);

endmodule

// File: rtl/eth_cks_sched.sv
// Schedules UDP and ICMP checksum jobs onto the shared checksum engine and
// owns the IP identification counter.
module eth_cks_sched
    import eth_cks_pkg::*;
#(
    parameter int unsigned TRIG_LEN    = 4,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [15:0] IDENT_INIT  = 16'h0
) (
    input  logic        CLK_125M,
    input  logic        SYS_RST,
    input  logic        UDP_REQ,
    input  logic [31:0] UDP_REQ_SUM,
    input  logic [15:0] UDP_REQ_LEN,
    input  logic [31:0] UDP_REQ_IP,
    output logic        UDP_ACK,
    input  logic        ICMP_REQ,
    input  logic [31:0] ICMP_REQ_SUM,
    input  logic [31:0] ICMP_REQ_IP,
    output logic        ICMP_ACK,
    output logic        TRIG_UDP_CKS,
    output logic        TRIG_ICMP_CKS,
    output logic [31:0] UDP_DATA_SUM,
    output logic [15:0] UDP_DATA_LEN,
    output logic [31:0] ICMP_DATA_SUM,
    output logic [31:0] PC_IP,
    output logic [15:0] IP_IDENTIF,
    input  logic        TRIG_TX_CKS,
    output logic        CKS_ERR,
    output logic        BUSY
);

    localparam logic [15:0] TRIG_LAST    = 16'(TRIG_LEN - 1);
    localparam logic [15:0] GAP_LAST     = 16'(GAP_CYC - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    cks_state_e  state_q, state_d;
    logic        src_q, src_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        tx_d1_q, tx_d1_d;
    logic [15:0] ident_q, ident_d;
    logic [31:0] udp_sum_q, udp_sum_d;
    logic [15:0] udp_len_q, udp_len_d;
    logic [31:0] icmp_sum_q, icmp_sum_d;
    logic [31:0] pc_ip_q, pc_ip_d;

    logic arb_grant;
    logic arb_load;
    logic tx_done;

    cks_rr_arb2 u_arb (
        .clk      (CLK_125M),
        .srst     (SYS_RST),
        .req_udp  (UDP_REQ),
        .req_icmp (ICMP_REQ),
        .load     (arb_load),
        .load_src (src_q),
        .grant    (arb_grant)
    );

    // Only a fresh rising edge of the engine's done level counts.
    assign tx_done = TRIG_TX_CKS & ~tx_d1_q;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ident_d    = ident_q;
        udp_sum_d  = udp_sum_q;
        udp_len_d  = udp_len_q;
        icmp_sum_d = icmp_sum_q;
        pc_ip_d    = pc_ip_q;
        tx_d1_d    = TRIG_TX_CKS;
        arb_load   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (UDP_REQ || ICMP_REQ) begin
                    src_d   = arb_grant;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                arb_load = 1'b1;
                if (src_q == SRC_UDP) begin
                    udp_sum_d  = UDP_REQ_SUM;
                    udp_len_d  = UDP_REQ_LEN;
                    icmp_sum_d = 32'h0;
                    pc_ip_d    = UDP_REQ_IP;
                end else begin
                    udp_sum_d  = 32'h0;
                    udp_len_d  = 16'h0;
                    icmp_sum_d = ICMP_REQ_SUM;
                    pc_ip_d    = ICMP_REQ_IP;
                end
                cnt_d   = 16'h0;
                state_d = ST_TRIG;
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    cnt_d   = 16'h0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WAIT: begin
                // A genuine done in the last watchdog cycle still wins.
                if (tx_done) begin
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                if (!err_q) begin
                    ident_d = ident_q + 16'd1;
                end
                cnt_d   = 16'h0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 16'h0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_125M) begin
        if (SYS_RST) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_UDP;
            cnt_q      <= 16'h0;
            err_q      <= 1'b0;
            tx_d1_q    <= 1'b0;
            ident_q    <= IDENT_INIT;
            udp_sum_q  <= 32'h0;
            udp_len_q  <= 16'h0;
            icmp_sum_q <= 32'h0;
            pc_ip_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            tx_d1_q    <= tx_d1_d;
            ident_q    <= ident_d;
            udp_sum_q  <= udp_sum_d;
            udp_len_q  <= udp_len_d;
            icmp_sum_q <= icmp_sum_d;
            pc_ip_q    <= pc_ip_d;
        end
    end

    assign TRIG_UDP_CKS  = (state_q == ST_TRIG) && (src_q == SRC_UDP);
    assign TRIG_ICMP_CKS = (state_q == ST_TRIG) && (src_q == SRC_ICMP);
    assign UDP_ACK       = (state_q == ST_DONE) && (src_q == SRC_UDP);
    assign ICMP_ACK      = (state_q == ST_DONE) && (src_q == SRC_ICMP);
    assign CKS_ERR       = (state_q == ST_DONE) && err_q;
    assign BUSY          = (state_q != ST_IDLE);
    assign UDP_DATA_SUM  = udp_sum_q;
    assign UDP_DATA_LEN  = udp_len_q;
    assign ICMP_DATA_SUM = icmp_sum_q;
    assign PC_IP         = pc_ip_q;
    assign IP_IDENTIF    = ident_q;

endmodule

// File: tb/tb_eth_cks_sched.sv
// Directed bench for eth_cks_sched: a simple engine model answers triggers
// N cycles after their rising edge; a second instance covers the ident wrap.
module tb_eth_cks_sched;

    localparam int ENG_N = 16;

    logic        CLK_125M;
    logic        SYS_RST;
    logic        UDP_REQ;
    logic [31:0] UDP_REQ_SUM;
    logic [15:0] UDP_REQ_LEN;
    logic [31:0] UDP_REQ_IP;
    logic        UDP_ACK;
    logic        ICMP_REQ;
    logic [31:0] ICMP_REQ_SUM;
    logic [31:0] ICMP_REQ_IP;
    logic        ICMP_ACK;
    logic        TRIG_UDP_CKS;
    logic        TRIG_ICMP_CKS;
    logic [31:0] UDP_DATA_SUM;
    logic [15:0] UDP_DATA_LEN;
    logic [31:0] ICMP_DATA_SUM;
    logic [31:0] PC_IP;
    logic [15:0] IP_IDENTIF;
    logic        TRIG_TX_CKS;
    logic        CKS_ERR;
    logic        BUSY;

    logic        UDP_REQ_2;
    logic        UDP_ACK_2;
    logic        ICMP_ACK_2;
    logic        TRIG_UDP_CKS_2;
    logic        TRIG_ICMP_CKS_2;
    logic [31:0] UDP_DATA_SUM_2;
    logic [15:0] UDP_DATA_LEN_2;
    logic [31:0] ICMP_DATA_SUM_2;
    logic [31:0] PC_IP_2;
    logic [15:0] IP_IDENTIF_2;
    logic        TRIG_TX_CKS_2;
    logic        CKS_ERR_2;
    logic        BUSY_2;

    int tests_run    = 0;
    int tests_failed = 0;

    eth_cks_sched dut (
        .CLK_125M      (CLK_125M),
        .SYS_RST       (SYS_RST),
        .UDP_REQ       (UDP_REQ),
        .UDP_REQ_SUM   (UDP_REQ_SUM),
        .UDP_REQ_LEN   (UDP_REQ_LEN),
        .UDP_REQ_IP    (UDP_REQ_IP),
        .UDP_ACK       (UDP_ACK),
        .ICMP_REQ      (ICMP_REQ),
        .ICMP_REQ_SUM  (ICMP_REQ_SUM),
        .ICMP_REQ_IP   (ICMP_REQ_IP),
        .ICMP_ACK      (ICMP_ACK),
        .TRIG_UDP_CKS  (TRIG_UDP_CKS),
        .TRIG_ICMP_CKS (TRIG_ICMP_CKS),
        .UDP_DATA_SUM  (UDP_DATA_SUM),
        .UDP_DATA_LEN  (UDP_DATA_LEN),
        .ICMP_DATA_SUM (ICMP_DATA_SUM),
        .PC_IP         (PC_IP),
        .IP_IDENTIF    (IP_IDENTIF),
        .TRIG_TX_CKS   (TRIG_TX_CKS),
        .CKS_ERR       (CKS_ERR),
        .BUSY          (BUSY)
    );

    eth_cks_sched #(.IDENT_INIT(16'hFFFF)) dut2 (
        .CLK_125M      (CLK_125M),
        .SYS_RST       (SYS_RST),
        .UDP_REQ       (UDP_REQ_2),
        .UDP_REQ_SUM   (32'h0000_0042),
        .UDP_REQ_LEN   (16'd4),
        .UDP_REQ_IP    (32'h0A00_0009),
        .UDP_ACK       (UDP_ACK_2),
        .ICMP_REQ      (1'b0),
        .ICMP_REQ_SUM  (32'h0),
        .ICMP_REQ_IP   (32'h0),
        .ICMP_ACK      (ICMP_ACK_2),
        .TRIG_UDP_CKS  (TRIG_UDP_CKS_2),
        .TRIG_ICMP_CKS (TRIG_ICMP_CKS_2),
        .UDP_DATA_SUM  (UDP_DATA_SUM_2),
        .UDP_DATA_LEN  (UDP_DATA_LEN_2),
        .ICMP_DATA_SUM (ICMP_DATA_SUM_2),
        .PC_IP         (PC_IP_2),
        .IP_IDENTIF    (IP_IDENTIF_2),
        .TRIG_TX_CKS   (TRIG_TX_CKS_2),
        .CKS_ERR       (CKS_ERR_2),
        .BUSY          (BUSY_2)
    );

    initial CLK_125M = 1'b0;
    always #4 CLK_125M = ~CLK_125M;

    // Engine model: done level rises ENG_N cycles after a trigger rising edge,
    // falls two cycles later; mode 1 never answers. Idle DUT clears it.
    int         eng_cnt   = 0;
    logic       eng_tx    = 1'b0;
    logic       trig_prev = 1'b0;
    logic       tx_force;
    logic [1:0] eng_mode;

    assign TRIG_TX_CKS = eng_tx | tx_force;

    always @(negedge CLK_125M) begin
        trig_prev <= TRIG_UDP_CKS | TRIG_ICMP_CKS;
        if (!BUSY || eng_mode != 2'd0) begin
            eng_cnt <= 0;
            eng_tx  <= 1'b0;
        end else if (eng_cnt == 0) begin
            if ((TRIG_UDP_CKS || TRIG_ICMP_CKS) && !trig_prev) eng_cnt <= 1;
        end else begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == ENG_N) eng_tx <= 1'b1;
            if (eng_cnt == ENG_N + 2) begin
                eng_tx  <= 1'b0;
                eng_cnt <= 0;
            end
        end
    end

    logic [127:0] ops_now;
    logic [117:0] outs_now;
    logic [117:0] outs_now_2;
    assign ops_now    = {UDP_DATA_SUM, UDP_DATA_LEN, ICMP_DATA_SUM, PC_IP, IP_IDENTIF};
    assign outs_now   = {UDP_ACK, ICMP_ACK, TRIG_UDP_CKS, TRIG_ICMP_CKS, CKS_ERR, BUSY,
                         UDP_DATA_SUM, UDP_DATA_LEN, ICMP_DATA_SUM, PC_IP};
    assign outs_now_2 = {UDP_ACK_2, ICMP_ACK_2, TRIG_UDP_CKS_2, TRIG_ICMP_CKS_2, CKS_ERR_2, BUSY_2,
                         UDP_DATA_SUM_2, UDP_DATA_LEN_2, ICMP_DATA_SUM_2, PC_IP_2};

    // Observations of one job, gathered by wait_ack and judged by the tests.
    int           obs_cyc;
    int           obs_first;
    int           obs_tu;
    int           obs_ti;
    logic         obs_u;
    logic         obs_i;
    logic         obs_err;
    logic         obs_overlap;
    logic         obs_unstable;
    logic [127:0] obs_ops;

    task automatic wait_ack(input int max_cyc);
        obs_cyc = 0; obs_first = 0; obs_tu = 0; obs_ti = 0;
        obs_u = 1'b0; obs_i = 1'b0; obs_err = 1'b0;
        obs_overlap = 1'b0; obs_unstable = 1'b0; obs_ops = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge CLK_125M);
            if (TRIG_UDP_CKS) obs_tu++;
            if (TRIG_ICMP_CKS) obs_ti++;
            if (TRIG_UDP_CKS && TRIG_ICMP_CKS) obs_overlap = 1'b1;
            if (obs_first == 0 && (TRIG_UDP_CKS || TRIG_ICMP_CKS)) begin
                obs_first = c;
                obs_ops   = ops_now;
            end else if (obs_first != 0 && ops_now !== obs_ops) begin
                obs_unstable = 1'b1;
            end
            if (UDP_ACK || ICMP_ACK) begin
                obs_cyc = c;
                obs_u   = UDP_ACK;
                obs_i   = ICMP_ACK;
                obs_err = CKS_ERR;
                break;
            end
        end
        $display("[TB] job ack_u=%0b ack_i=%0b err=%0b latency=%0d trig_u=%0d trig_i=%0d ident=%04h",
                 obs_u, obs_i, obs_err, obs_cyc, obs_tu, obs_ti, IP_IDENTIF);
    endtask

    task automatic do_reset();
        SYS_RST  = 1'b1;
        UDP_REQ  = 1'b0;
        ICMP_REQ = 1'b0;
        tx_force = 1'b0;
        eng_mode = 2'd0;
        repeat (3) @(negedge CLK_125M);
        SYS_RST = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (outs_now !== 118'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, expected 0", outs_now);
        end
        tests_run++;
        if (IP_IDENTIF !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_ident: got %h, expected 0000", IP_IDENTIF);
        end
        tests_run++;
        if (outs_now_2 !== 118'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs_2: got %h, expected 0", outs_now_2);
        end
        tests_run++;
        if (IP_IDENTIF_2 !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL reset_ident_2: got %h, expected ffff", IP_IDENTIF_2);
        end
    endtask

    task automatic test_udp_single();
        UDP_REQ_SUM = 32'h0001_2345;
        UDP_REQ_LEN = 16'd18;
        UDP_REQ_IP  = 32'hC0A8_0001;
        UDP_REQ     = 1'b1;
        wait_ack(100);
        UDP_REQ = 1'b0;
        tests_run++;
        if ({obs_u, obs_i, obs_err} !== 3'b100) begin
            tests_failed++;
            $display("FAIL udp_ack: got u/i/err=%b%b%b, expected 100", obs_u, obs_i, obs_err);
        end
        tests_run++;
        if (obs_cyc !== 19) begin
            tests_failed++;
            $display("FAIL udp_latency: got %0d, expected 19", obs_cyc);
        end
        tests_run++;
        if (obs_tu !== 4 || obs_ti !== 0) begin
            tests_failed++;
            $display("FAIL udp_trig_len: got u=%0d i=%0d, expected u=4 i=0", obs_tu, obs_ti);
        end
        tests_run++;
        if (obs_ops !== {32'h0001_2345, 16'd18, 32'h0, 32'hC0A8_0001, 16'h0000}) begin
            tests_failed++;
            $display("FAIL udp_operands: got %h", obs_ops);
        end
        tests_run++;
        if (obs_unstable !== 1'b0) begin
            tests_failed++;
            $display("FAIL udp_operand_stable: got unstable=%b, expected 0", obs_unstable);
        end
        @(negedge CLK_125M);
        tests_run++;
        if (IP_IDENTIF !== 16'h0001) begin
            tests_failed++;
            $display("FAIL udp_ident: got %h, expected 0001", IP_IDENTIF);
        end
        @(negedge CLK_125M);
        tests_run++;
        if (BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL udp_busy_gap: got %b, expected 1", BUSY);
        end
        @(negedge CLK_125M);
        tests_run++;
        if (BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL udp_busy_idle: got %b, expected 0", BUSY);
        end
    endtask

    task automatic test_tie();
        do_reset();
        UDP_REQ_SUM  = 32'h0000_1111;
        UDP_REQ_LEN  = 16'd8;
        UDP_REQ_IP   = 32'h0A00_0001;
        ICMP_REQ_SUM = 32'h0002_ABCD;
        ICMP_REQ_IP  = 32'h0A00_0002;
        UDP_REQ  = 1'b1;
        ICMP_REQ = 1'b1;
        wait_ack(100);
        UDP_REQ = 1'b0;
        tests_run++;
        if ({obs_u, obs_i} !== 2'b10 || obs_tu !== 4 || obs_ti !== 0) begin
            tests_failed++;
            $display("FAIL tie_first: got u/i=%b%b trig u=%0d i=%0d, expected 10 u=4 i=0",
                     obs_u, obs_i, obs_tu, obs_ti);
        end
        wait_ack(100);
        ICMP_REQ = 1'b0;
        tests_run++;
        if ({obs_u, obs_i, obs_err} !== 3'b010 || obs_ti !== 4 || obs_tu !== 0 || obs_overlap !== 1'b0) begin
            tests_failed++;
            $display("FAIL tie_second: got u/i/err=%b%b%b trig u=%0d i=%0d ovl=%b, expected 010 u=0 i=4 ovl=0",
                     obs_u, obs_i, obs_err, obs_tu, obs_ti, obs_overlap);
        end
        tests_run++;
        if (obs_first - 1 !== 4) begin
            tests_failed++;
            $display("FAIL tie_idle_gap: got %0d cycles between ack and trigger, expected 4", obs_first - 1);
        end
        tests_run++;
        if (obs_ops !== {32'h0, 16'h0, 32'h0002_ABCD, 32'h0A00_0002, 16'h0001}) begin
            tests_failed++;
            $display("FAIL icmp_operands: got %h", obs_ops);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] order;
        order = 8'h0;
        do_reset();
        UDP_REQ  = 1'b1;
        ICMP_REQ = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_ack(100);
            order = {order[5:0], obs_u, obs_i};
        end
        UDP_REQ  = 1'b0;
        ICMP_REQ = 1'b0;
        tests_run++;
        if (order !== 8'b10_01_10_01) begin
            tests_failed++;
            $display("FAIL b2b_order: got %b, expected 10011001", order);
        end
        @(negedge CLK_125M);
        tests_run++;
        if (IP_IDENTIF !== 16'd4) begin
            tests_failed++;
            $display("FAIL b2b_ident: got %h, expected 0004", IP_IDENTIF);
        end
        repeat (2) @(negedge CLK_125M);
    endtask

    task automatic test_timeout();
        eng_mode = 2'd1;
        UDP_REQ  = 1'b1;
        wait_ack(400);
        UDP_REQ = 1'b0;
        tests_run++;
        if ({obs_u, obs_i, obs_err} !== 3'b101 || obs_cyc !== 261) begin
            tests_failed++;
            $display("FAIL timeout_ack: got u/i/err=%b%b%b latency=%0d, expected 101 latency=261",
                     obs_u, obs_i, obs_err, obs_cyc);
        end
        @(negedge CLK_125M);
        tests_run++;
        if (IP_IDENTIF !== 16'd4) begin
            tests_failed++;
            $display("FAIL timeout_ident: got %h, expected 0004", IP_IDENTIF);
        end
        repeat (2) @(negedge CLK_125M);
        tests_run++;
        if (BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_busy: got %b, expected 0", BUSY);
        end
    endtask

    task automatic test_stuck_tx();
        eng_mode = 2'd1;
        tx_force = 1'b1;
        UDP_REQ  = 1'b1;
        wait_ack(400);
        tx_force = 1'b0;
        eng_mode = 2'd0;
        tests_run++;
        if ({obs_u, obs_err} !== 2'b11 || obs_cyc !== 261) begin
            tests_failed++;
            $display("FAIL stuck_timeout: got u/err=%b%b latency=%0d, expected 11 latency=261",
                     obs_u, obs_err, obs_cyc);
        end
        wait_ack(100);
        UDP_REQ = 1'b0;
        tests_run++;
        if ({obs_u, obs_err} !== 2'b10 || obs_cyc !== 22) begin
            tests_failed++;
            $display("FAIL stuck_recover: got u/err=%b%b latency=%0d, expected 10 latency=22",
                     obs_u, obs_err, obs_cyc);
        end
        @(negedge CLK_125M);
        tests_run++;
        if (IP_IDENTIF !== 16'd5) begin
            tests_failed++;
            $display("FAIL stuck_ident: got %h, expected 0005", IP_IDENTIF);
        end
        repeat (2) @(negedge CLK_125M);
    endtask

    task automatic test_reset_in_wait();
        logic ack_seen;
        ack_seen = 1'b0;
        UDP_REQ  = 1'b1;
        repeat (7) begin
            @(negedge CLK_125M);
            ack_seen = ack_seen | UDP_ACK | ICMP_ACK;
        end
        tests_run++;
        if (BUSY !== 1'b1 || TRIG_UDP_CKS !== 1'b0 || ack_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_wait_pre: got busy=%b trig=%b ack=%b, expected 1 0 0",
                     BUSY, TRIG_UDP_CKS, ack_seen);
        end
        SYS_RST = 1'b1;
        @(negedge CLK_125M);
        tests_run++;
        if (outs_now !== 118'h0 || IP_IDENTIF !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_wait_outputs: got %h ident=%h, expected 0 ident=0000", outs_now, IP_IDENTIF);
        end
        SYS_RST = 1'b0;
        wait_ack(100);
        UDP_REQ = 1'b0;
        tests_run++;
        if ({obs_u, obs_err} !== 2'b10 || obs_cyc !== 19 || obs_tu !== 4) begin
            tests_failed++;
            $display("FAIL rst_wait_reserve: got u/err=%b%b latency=%0d trig=%0d, expected 10 19 4",
                     obs_u, obs_err, obs_cyc, obs_tu);
        end
        repeat (3) @(negedge CLK_125M);
    endtask

    task automatic test_ident_wrap();
        int   k;
        logic ack2;
        logic err2;
        ack2 = 1'b0;
        err2 = 1'b0;
        tests_run++;
        if (IP_IDENTIF_2 !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL wrap_init: got %h, expected ffff", IP_IDENTIF_2);
        end
        UDP_REQ_2 = 1'b1;
        k = 0;
        while (!TRIG_UDP_CKS_2 && k < 20) begin
            @(negedge CLK_125M);
            k++;
        end
        repeat (6) @(negedge CLK_125M);
        TRIG_TX_CKS_2 = 1'b1;
        for (int c = 0; c < 30 && !ack2; c++) begin
            @(negedge CLK_125M);
            if (c == 1) TRIG_TX_CKS_2 = 1'b0;
            if (UDP_ACK_2) begin
                ack2 = 1'b1;
                err2 = CKS_ERR_2;
            end
        end
        TRIG_TX_CKS_2 = 1'b0;
        UDP_REQ_2 = 1'b0;
        $display("[TB] job dut2 ack=%0b err=%0b", ack2, err2);
        tests_run++;
        if ({ack2, err2} !== 2'b10) begin
            tests_failed++;
            $display("FAIL wrap_ack: got ack/err=%b%b, expected 10", ack2, err2);
        end
        @(negedge CLK_125M);
        tests_run++;
        if (IP_IDENTIF_2 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL wrap_ident: got %h, expected 0000", IP_IDENTIF_2);
        end
    endtask

    initial begin
        SYS_RST       = 1'b1;
        UDP_REQ       = 1'b0;
        UDP_REQ_SUM   = 32'h0;
        UDP_REQ_LEN   = 16'h0;
        UDP_REQ_IP    = 32'h0;
        ICMP_REQ      = 1'b0;
        ICMP_REQ_SUM  = 32'h0;
        ICMP_REQ_IP   = 32'h0;
        UDP_REQ_2     = 1'b0;
        TRIG_TX_CKS_2 = 1'b0;
        tx_force      = 1'b0;
        eng_mode      = 2'd0;
        repeat (4) @(negedge CLK_125M);
        SYS_RST = 1'b0;
        @(negedge CLK_125M);

        test_reset();
        test_udp_single();
        test_tie();
        test_back_to_back();
        test_timeout();
        test_stuck_tx();
        test_reset_in_wait();
        test_ident_wrap();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
